div32_iterative: RTL
====================

# div32_iterative

Iterative radix-2 restoring integer divider for the execute unit. It is the counterpart of the pipelined 32x32 multiplier and implements RISC-V M-extension DIV/DIVU/REM/REMU. One operation is in flight at a time, controlled by a start/busy/done handshake. Results follow RISC-V semantics, including divide-by-zero and signed overflow.

## Interface
- OPERAND_SIZE, 32, dividend/divisor/result width (only 32 is verified)
- clk_i  input  1  clock; all registers update on the falling edge, matching the multiplier pipeline
- rst_n_i  input  1  reset, asynchronous and active-low
- start_i  input  1  request; sampled only while the block is idle
- signed_div_i  input  1  1 = signed (DIV/REM), 0 = unsigned (DIVU/REMU)
- rem_i  input  1  1 = return remainder, 0 = return quotient
- X_i  input  OPERAND_SIZE  dividend, captured when start is accepted
- Y_i  input  OPERAND_SIZE  divisor, captured when start is accepted
- busy_o  output  1  high while an operation is in progress
- done_o  output  1  one-cycle pulse when Result_o becomes valid
- Result_o  output  OPERAND_SIZE  quotient or remainder; holds until the next done_o

## Operation
- States: IDLE, CALC, FIX.
- **IDLE, start_i=1 (acceptance edge):**
  - latch signed_div_i, rem_i, sign(X) and sign(Y);
  - latch the operand magnitudes: two's-complement absolute value when signed, raw value otherwise;
  - clear the 33-bit partial remainder and the 5-bit iteration counter.
- **Special cases, detected at the acceptance edge from X_i/Y_i.** These stay in IDLE, write Result_o and pulse done_o at the same edge:
  - Y=0: quotient = all ones, remainder = X_i (unmodified);
  - signed, X=0x80000000, Y=0xFFFFFFFF: quotient = 0x80000000, remainder = 0;
  - in both cases, rem_i selects which value goes to Result_o.
- **Otherwise go to CALC.** Each edge performs one restoring step:
  - shift {rem, dividend MSB} left;
  - trial-subtract the divisor magnitude;
  - if non-negative, keep the difference and shift 1 into the quotient; else restore and shift 0.
- The counter increments every CALC edge. After 32 steps (counter wraps 31→0), go to FIX.
- **FIX (one edge):**
  - negate the quotient if signed and sign(X)≠sign(Y);
  - negate the remainder if signed and sign(X)=1;
  - write the selected value to Result_o, pulse done_o, return to IDLE.
- Width rules: the partial remainder is OPERAND_SIZE+1 bits. Magnitude of 0x80000000 is 0x80000000 treated as unsigned, with no overflow.
- start_i while busy_o=1 is ignored; operand inputs are don't-care after acceptance.
- Asserting rst_n_i at any time, including mid-CALC, returns to IDLE immediately. The operation is discarded and no done_o is produced.

## Timing
- Reset values: busy_o=0, done_o=0, Result_o=0, state IDLE, counter 0.
- Normal latency, with start accepted at edge 0:
  - CALC steps occur on edges 1..32;
  - FIX on edge 33 drives Result_o, with done_o=1 for the cycle following edge 33;
  - busy_o=1 from edge 0 until edge 33.
- Special-case latency: Result_o valid and done_o=1 in the cycle after the acceptance edge; busy_o stays 0.
- done_o falls at the next edge unless that edge completes another operation. A special case accepted back-to-back keeps done_o high for consecutive cycles.
- The block is in IDLE during the done_o cycle, so start_i asserted then is accepted. Throughput is therefore one division per 34 cycles.
- Result_o changes only on a completion edge.

## Test plan
- Unsigned 100 ÷ 7, rem_i=0 → Result_o=14 with done_o 34 edges after start; repeat with rem_i=1 → 2.
- Signed −7 ÷ 2: quotient 0xFFFFFFFD (−3), remainder 0xFFFFFFFF (−1).
- Signed 7 ÷ −2: quotient 0xFFFFFFFD, remainder 1.
- Corner cases:
  - X=5, Y=0, unsigned or signed: quotient 0xFFFFFFFF, remainder 5, done_o one cycle after start, busy_o never high;
  - signed 0x80000000 ÷ 0xFFFFFFFF: quotient 0x80000000, remainder 0;
  - unsigned 0x80000000 ÷ 0xFFFFFFFF: quotient 0, remainder 0x80000000.
- start_i pulsed with new operands at edge 10 of a running op → ignored, first result unchanged. Second start during the done_o cycle → accepted, second done_o 34 edges later.
- rst_n_i low for part of a cycle at CALC step 15 → busy_o, done_o and Result_o go to 0 immediately, no done_o follows. A fresh 0xFFFFFFFF ÷ 1 unsigned then returns 0xFFFFFFFF.

Source files
------------

// File: rtl/div32_iterative_if.sv
// Request/response bundle between the execute unit and the iterative divider.
// The execute unit drives the master side; the divider is the slave.
interface div32_iterative_if #(
    parameter int unsigned OPERAND_SIZE = 32
);
    logic                    start_i;
    logic                    signed_div_i;
    logic                    rem_i;
    logic [OPERAND_SIZE-1:0] X_i;
    logic [OPERAND_SIZE-1:0] Y_i;
    logic                    busy_o;
    logic                    done_o;
    logic [OPERAND_SIZE-1:0] Result_o;

    modport master (
        output start_i,
        output signed_div_i,
        output rem_i,
        output X_i,
        output Y_i,
        input  busy_o,
        input  done_o,
        input  Result_o
    );

    modport slave (
        input  start_i,
        input  signed_div_i,
        input  rem_i,
        input  X_i,
        input  Y_i,
        output busy_o,
        output done_o,
        output Result_o
    );
endinterface

// File: rtl/div32_iterative.sv
// Iterative radix-2 restoring divider implementing RISC-V DIV/DIVU/REM/REMU.
// Registers update on the falling clock edge to line up with the multiplier pipeline.
module div32_iterative #(
    parameter int unsigned OPERAND_SIZE = 32
) (
    input logic              clk_i,
    input logic              rst_n_i,
    div32_iterative_if.slave bus
);
    localparam int unsigned W    = OPERAND_SIZE;
    localparam int unsigned CntW = $clog2(OPERAND_SIZE);
    localparam logic [CntW-1:0] LastStep = CntW'(OPERAND_SIZE - 1);
    localparam logic [W-1:0]    AllOnes  = {W{1'b1}};
    localparam logic [W-1:0]    MinNeg   = {1'b1, {(W-1){1'b0}}};

    typedef enum logic [1:0] {
        StIdle,
        StCalc,
        StFix
    } state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [W:0]      rem_q, rem_d;
    logic [W-1:0]    quo_q, quo_d;
    logic [W-1:0]    dvs_q, dvs_d;
    logic            sdiv_q, sdiv_d;
    logic            remsel_q, remsel_d;
    logic            sx_q, sx_d;
    logic            sy_q, sy_d;
    logic [W-1:0]    result_q, result_d;
    logic            done_q, done_d;

    logic            x_neg, y_neg;
    logic [W-1:0]    x_mag, y_mag;
    logic            div_by_zero, sign_ovf;
    logic [W+1:0]    shifted, diff;
    logic [W-1:0]    q_fix, r_fix;

    always_comb begin
        x_neg = bus.signed_div_i & bus.X_i[W-1];
        y_neg = bus.signed_div_i & bus.Y_i[W-1];
        // Magnitude of the most negative value wraps onto itself, read as unsigned.
        x_mag = x_neg ? (~bus.X_i + 1'b1) : bus.X_i;
        y_mag = y_neg ? (~bus.Y_i + 1'b1) : bus.Y_i;

        div_by_zero = (bus.Y_i == '0);
        sign_ovf    = bus.signed_div_i && (bus.X_i == MinNeg) && (bus.Y_i == AllOnes);

        // One extra top bit keeps the trial difference sign visible.
        shifted = {rem_q, quo_q[W-1]};
        diff    = shifted - {2'b00, dvs_q};

        q_fix = (sdiv_q && (sx_q ^ sy_q)) ? (~quo_q + 1'b1) : quo_q;
        r_fix = (sdiv_q && sx_q) ? (~rem_q[W-1:0] + 1'b1) : rem_q[W-1:0];
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        dvs_d    = dvs_q;
        sdiv_d   = sdiv_q;
        remsel_d = remsel_q;
        sx_d     = sx_q;
        sy_d     = sy_q;
        result_d = result_q;
        done_d   = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (bus.start_i) begin
                    sdiv_d   = bus.signed_div_i;
                    remsel_d = bus.rem_i;
                    sx_d     = bus.X_i[W-1];
                    sy_d     = bus.Y_i[W-1];
                    quo_d    = x_mag;
                    dvs_d    = y_mag;
                    rem_d    = '0;
                    cnt_d    = '0;
                    if (div_by_zero) begin
                        result_d = bus.rem_i ? bus.X_i : AllOnes;
                        done_d   = 1'b1;
                    end else if (sign_ovf) begin
                        result_d = bus.rem_i ? '0 : MinNeg;
                        done_d   = 1'b1;
                    end else begin
                        state_d = StCalc;
                    end
                end
            end
            StCalc: begin
                cnt_d = cnt_q + 1'b1;
                if (!diff[W+1]) begin
                    rem_d = diff[W:0];
                    quo_d = {quo_q[W-2:0], 1'b1};
                end else begin
                    rem_d = shifted[W:0];
                    quo_d = {quo_q[W-2:0], 1'b0};
                end
                if (cnt_q == LastStep) begin
                    state_d = StFix;
                end
            end
            StFix: begin
                result_d = remsel_q ? r_fix : q_fix;
                done_d   = 1'b1;
                state_d  = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(negedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            dvs_q    <= '0;
            sdiv_q   <= 1'b0;
            remsel_q <= 1'b0;
            sx_q     <= 1'b0;
            sy_q     <= 1'b0;
            result_q <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            dvs_q    <= dvs_d;
            sdiv_q   <= sdiv_d;
            remsel_q <= remsel_d;
            sx_q     <= sx_d;
            sy_q     <= sy_d;
            result_q <= result_d;
            done_q   <= done_d;
        end
    end

    assign bus.busy_o   = (state_q != StIdle);
    assign bus.done_o   = done_q;
    assign bus.Result_o = result_q;

endmodule
